muldiv_unit: RTL
================

MULDIV_UNIT -- requirements
Module: muldiv_unit

Interface
REQ-001 SHALL have a single clock and an asynchronous, active-low reset.
REQ-002 clk  input  1  rising-edge clock.
REQ-003 rst  input  1  asynchronous active-low reset.
REQ-004 start  input  1  request; accepted on a rising edge when busy=0.
REQ-005 funct3  input  3  RV32M op: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
REQ-006 rs1_data  input  32  operand A (multiplicand/dividend), from register-file read port rs1.
REQ-007 rs2_data  input  32  operand B (multiplier/divisor), from register-file read port rs2.
REQ-008 rd_in  input  5  destination register index.
REQ-009 busy  output  1  high from the accepting edge until done clears.
REQ-010 done  output  1  one-cycle completion pulse.
REQ-011 result  output  32  value for the register-file write_rd_data; held until the next accept.
REQ-012 rd_out  output  5  latched rd_in; drives register-file target_reg.
REQ-013 write_reg  output  1  equals done AND rd_out != 0; drives register-file write_reg.

Function
REQ-014 SHALL implement FSM states IDLE, CALC, DONE.
- IDLE->CALC on start.
- CALC->DONE after 32 iterations.
- DONE->IDLE, or DONE->CALC if start is high in DONE.
REQ-015 SHALL latch funct3, both operands and rd_in on the accepting edge; input changes afterwards SHALL have no effect.
REQ-016 SHALL ignore start while in CALC.
REQ-017 Multiply: radix-2 shift-add on operand magnitudes, 64-bit product.
- Operand signedness: MULH signed x signed; MULHSU signed x unsigned; MULHU unsigned x unsigned.
- Product sign fixed at DONE.
- MUL returns product[31:0]; MULH/MULHSU/MULHU return product[63:32].
REQ-018 Divide: restoring, one quotient bit per cycle on magnitudes.
- Quotient sign = XOR of operand signs (signed ops only).
- Remainder sign = dividend sign.
REQ-019 Normal ops: done SHALL be high during the cycle that begins at the 32nd rising edge after the accepting edge.
REQ-020 Divide by zero SHALL bypass CALC and enter DONE on the edge after accept (1-cycle latency).
- DIV/DIVU return 0xFFFFFFFF.
- REM/REMU return rs1_data.
REQ-021 Signed overflow (DIV/REM, 0x80000000 by 0xFFFFFFFF) SHALL take the same 1-cycle fast path; DIV returns 0x80000000, REM returns 0.
REQ-022 rd_in=0 SHALL still run the full computation and pulse done, with write_reg held at 0.
REQ-023 busy SHALL be 0 in IDLE, and 1 in CALC and DONE.
REQ-024 done and write_reg SHALL never be high for more than one consecutive cycle per accepted request.

Reset
REQ-025 rst low SHALL immediately force the FSM to IDLE from any state.
REQ-026 During reset: busy=0, done=0, write_reg=0, result=0, rd_out=0, iteration counter=0.
REQ-027 An operation in flight when rst asserts SHALL be discarded, with no done and no write_reg afterwards.

Configuration
REQ-028 Macro MULDIV_DIV_EN compiles in the divider datapath.
- Defined: all eight ops as specified above.
- Undefined: funct3[2]=1 requests complete in 1 cycle with result=0 and write_reg=0; done still pulses; multiply behaviour unchanged.

Structure
REQ-029 Package muldiv_pkg SHALL hold:
- the funct3 op enum;
- the FSM state enum;
- constants XLEN=32 and ITER=32.
REQ-030 Sub-module muldiv_sign_adj (combinational conditional negate/absolute value, 32 and 64 bit) SHALL be used for operand conditioning and result sign correction; no other sub-modules.

Verification
REQ-031 MUL, rs1=7, rs2=6, rd_in=5 -> done 32 cycles after accept; result=0x0000002A, rd_out=5, write_reg=1.
REQ-032 MULH 0x80000000 x 0x80000000 -> result=0x40000000. MULHU 0xFFFFFFFF x 0xFFFFFFFF -> result=0xFFFFFFFE.
REQ-033 DIV -7/2 -> result=0xFFFFFFFD. REM -7/2 -> result=0xFFFFFFFF. DIVU 5/0 -> result=0xFFFFFFFF with done 1 cycle after accept.
REQ-034 DIV 0x80000000 / 0xFFFFFFFF -> result=0x80000000 in 1 cycle. The same operands with REM -> result=0.
REQ-035 Start MUL, assert rst at cycle 10, release, idle 40 cycles -> busy=0, done never pulses, result=0.
REQ-036 Back-to-back: start held high in DONE with new operands -> second result correct, with exactly two done pulses. rd_in=0 -> done pulses, write_reg stays 0.

Source files
------------

// File: rtl/muldiv_pkg.sv
// muldiv_pkg: shared types and constants for the RV32M multiply/divide unit.
// Divider datapath is compiled in only when MULDIV_DIV_EN is defined.
package muldiv_pkg;

  localparam int XLEN = 32;
  localparam int ITER = 32;
  localparam logic [XLEN-1:0] MIN_INT = {1'b1, {(XLEN-1){1'b0}}};

  typedef enum logic [2:0] {
    OP_MUL    = 3'b000,
    OP_MULH   = 3'b001,
    OP_MULHSU = 3'b010,
    OP_MULHU  = 3'b011,
    OP_DIV    = 3'b100,
    OP_DIVU   = 3'b101,
    OP_REM    = 3'b110,
    OP_REMU   = 3'b111
  } op_e;

  typedef enum logic [1:0] {
    S_IDLE,
    S_CALC,
    S_DONE
  } state_e;

endpackage

// File: rtl/muldiv_sign_adj.sv
// muldiv_sign_adj: conditional two's-complement negate.
// With neg_i tied to the sign bit it yields the absolute value.
module muldiv_sign_adj
  import muldiv_pkg::*;
#(
  parameter int W = XLEN
) (
  input  logic [W-1:0] val_i,
  input  logic         neg_i,
  output logic [W-1:0] val_o
);

  assign val_o = neg_i ? (~val_i + W'(1)) : val_i;

endmodule

// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative RV32M multiply/divide, one bit per cycle.
// Define MULDIV_DIV_EN to build the restoring divider.
module muldiv_unit
  import muldiv_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] rs1_data,
  input  logic [XLEN-1:0] rs2_data,
  input  logic [4:0]      rd_in,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result,
  output logic [4:0]      rd_out,
  output logic            write_reg
);

  state_e state_q, state_d;
  op_e    op_q, op_d, op_in;

  logic [4:0]        cnt_q, cnt_d;
  logic [4:0]        rd_q, rd_d;
  logic              neg_q, neg_d;
  logic              nowr_q, nowr_d;
  logic              fast_q, fast_d;
  logic [XLEN-1:0]   opd_q, opd_d;
  logic [XLEN-1:0]   res_q, res_d;
  logic [2*XLEN-1:0] acc_q, acc_d;

  logic            is_div, a_sgn, b_sgn, a_neg, b_neg;
  logic [XLEN-1:0] a_mag, b_mag;
  logic            fast, fast_nowr;
  logic [XLEN-1:0] fast_res;

  assign op_in  = op_e'(funct3);
  assign is_div = funct3[2];
  assign a_sgn  = op_in inside {OP_MULH, OP_MULHSU, OP_DIV, OP_REM};
  assign b_sgn  = op_in inside {OP_MULH, OP_DIV, OP_REM};
  assign a_neg  = a_sgn & rs1_data[XLEN-1];
  assign b_neg  = b_sgn & rs2_data[XLEN-1];

  muldiv_sign_adj #(.W(XLEN)) u_abs_a (
    .val_i (rs1_data),
    .neg_i (a_neg),
    .val_o (a_mag)
  );

  muldiv_sign_adj #(.W(XLEN)) u_abs_b (
    .val_i (rs2_data),
    .neg_i (b_neg),
    .val_o (b_mag)
  );

  always_comb begin
    fast      = 1'b0;
    fast_nowr = 1'b0;
    fast_res  = '0;
`ifdef MULDIV_DIV_EN
    unique case (1'b1)
      is_div && (rs2_data == '0): begin
        fast     = 1'b1;
        fast_res = funct3[1] ? rs1_data : '1;
      end
      is_div && !funct3[0] && (rs1_data == MIN_INT)
        && (rs2_data == '1): begin
        fast     = 1'b1;
        fast_res = funct3[1] ? '0 : MIN_INT;
      end
      default: ;
    endcase
`else
    if (is_div) begin
      fast      = 1'b1;
      fast_nowr = 1'b1;
    end
`endif
  end

  // Shift-add step: acc = {partial hi, remaining multiplier bits}
  logic [XLEN:0]     mul_sum;
  logic [2*XLEN-1:0] mul_nxt, acc_nxt, prod_fix;
  logic [XLEN-1:0]   calc_res;

  assign mul_sum = {1'b0, acc_q[2*XLEN-1:XLEN]}
                 + (acc_q[0] ? {1'b0, opd_q} : '0);
  assign mul_nxt = {mul_sum, acc_q[XLEN-1:1]};

  muldiv_sign_adj #(.W(2*XLEN)) u_fix_p (
    .val_i (mul_nxt),
    .neg_i (neg_q),
    .val_o (prod_fix)
  );

`ifdef MULDIV_DIV_EN
  // Restoring step: acc = {remainder, dividend/quotient shift reg}
  logic [XLEN:0]     div_sh, div_sub;
  logic              div_ge;
  logic [2*XLEN-1:0] div_nxt;
  logic [XLEN-1:0]   div_sel, div_fix;

  assign div_sh  = {acc_q[2*XLEN-1:XLEN], acc_q[XLEN-1]};
  assign div_sub = div_sh - {1'b0, opd_q};
  assign div_ge  = ~div_sub[XLEN];
  assign div_nxt = {div_ge ? div_sub[XLEN-1:0] : div_sh[XLEN-1:0],
                    acc_q[XLEN-2:0], div_ge};
  assign div_sel = op_q[1] ? div_nxt[2*XLEN-1:XLEN]
                           : div_nxt[XLEN-1:0];

  muldiv_sign_adj #(.W(XLEN)) u_fix_d (
    .val_i (div_sel),
    .neg_i (neg_q),
    .val_o (div_fix)
  );

  assign acc_nxt = op_q[2] ? div_nxt : mul_nxt;
`else
  assign acc_nxt = mul_nxt;
`endif

  always_comb begin
    calc_res = (op_q == OP_MUL) ? prod_fix[XLEN-1:0]
                                : prod_fix[2*XLEN-1:XLEN];
`ifdef MULDIV_DIV_EN
    if (op_q[2]) calc_res = div_fix;
`endif
  end

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    cnt_d   = cnt_q;
    rd_d    = rd_q;
    neg_d   = neg_q;
    nowr_d  = nowr_q;
    fast_d  = fast_q;
    opd_d   = opd_q;
    acc_d   = acc_q;
    res_d   = res_q;
    unique case (state_q)
      S_CALC: begin
        acc_d = acc_nxt;
        cnt_d = cnt_q + 5'd1;
        if (cnt_q == 5'(ITER-1)) begin
          state_d = S_DONE;
          cnt_d   = '0;
          res_d   = fast_q ? opd_q : calc_res;
        end
      end
      default: begin
        state_d = S_IDLE;
        if (start) begin
          state_d = S_CALC;
          op_d    = op_in;
          rd_d    = rd_in;
          nowr_d  = fast_nowr;
          fast_d  = fast;
          neg_d   = (is_div && funct3[1]) ? a_neg : (a_neg ^ b_neg);
          opd_d   = is_div ? b_mag : a_mag;
          acc_d   = {{XLEN{1'b0}}, is_div ? a_mag : b_mag};
          cnt_d   = '0;
          // Early-out ops ride the final CALC cycle with a preset result
          if (fast) begin
            cnt_d = 5'(ITER-1);
            opd_d = fast_res;
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      op_q    <= OP_MUL;
      cnt_q   <= '0;
      rd_q    <= '0;
      neg_q   <= 1'b0;
      nowr_q  <= 1'b0;
      fast_q  <= 1'b0;
      opd_q   <= '0;
      acc_q   <= '0;
      res_q   <= '0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      cnt_q   <= cnt_d;
      rd_q    <= rd_d;
      neg_q   <= neg_d;
      nowr_q  <= nowr_d;
      fast_q  <= fast_d;
      opd_q   <= opd_d;
      acc_q   <= acc_d;
      res_q   <= res_d;
    end
  end

  assign busy      = (state_q != S_IDLE);
  assign done      = (state_q == S_DONE);
  assign result    = res_q;
  assign rd_out    = rd_q;
  assign write_reg = done & (|rd_q) & ~nowr_q;

endmodule
